// File: rtl/avr_loader_pkg.sv
// Shared definitions for the AVR UART flash loader: frame header, frame
// byte offsets and FSM state encodings for the loader and the UART receiver.
// Optional feature macro: LOADER_VERIFY_EN (adds the flash readback states).
package avr_loader_pkg;

  // First byte of every frame; anything else is ignored while idle.
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // Byte positions inside a frame: header, length high, length low, first data byte.
  localparam int OFS_HEADER = 0;
  localparam int OFS_LEN_H  = 1;
  localparam int OFS_LEN_L  = 2;
  localparam int OFS_DATA   = 3;

  // Loader FSM state encoding.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_H   = 4'd1,
    S_LEN_L   = 4'd2,
    S_DATA_L  = 4'd3,
    S_DATA_H  = 4'd4,
    S_WRITE   = 4'd5,
`ifdef LOADER_VERIFY_EN
    S_VERIFY1 = 4'd6,
    S_VERIFY2 = 4'd7,
`endif
    S_CSUM    = 4'd8,
    S_DONE    = 4'd9,
    S_ERR     = 4'd10
  } ld_state_e;

  // UART receiver state encoding.
  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver. Two-flop synchroniser, start bit confirmed at half
// a bit period, data and stop bits sampled mid-bit. Emits a one-cycle valid
// pulse with the byte, or a one-cycle frame_err pulse when the stop bit is 0.
module uart_rx_byte
  import avr_loader_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int BIT_CYC  = CLK_HZ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int TMR_W    = $clog2(BIT_CYC + 1);
  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(BIT_CYC - 1);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF_CYC - 1);

  logic             rx_meta_q, rx_sync_q;
  rx_state_e        state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // Synchronise the asynchronous serial line; idle level is high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= U_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit-timing state machine: find start, sample eight bits, check stop.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      U_IDLE: begin
        tmr_d = '0;
        if (!rx_sync_q) state_d = U_START;
      end
      U_START: begin
        if (tmr_q == HALF_LAST) begin
          tmr_d   = '0;
          bit_d   = '0;
          // A line that is high again at mid start bit was a glitch.
          state_d = rx_sync_q ? U_IDLE : U_DATA;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      U_DATA: begin
        if (tmr_q == BIT_LAST) begin
          tmr_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = U_STOP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      U_STOP: begin
        if (tmr_q == BIT_LAST) begin
          tmr_d   = '0;
          valid_d = rx_sync_q;
          ferr_d  = !rx_sync_q;
          state_d = U_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

  assign data      = shift_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/avr_flash_loader.sv
// UART bootloader for the AVR core. Receives A5 | LEN_H | LEN_L | words | CSUM,
// writes word i to FLASH address i, holds the core for the whole load and
// releases it only after the checksum passes. Any fault leaves the core held.
// Optional feature macro: LOADER_VERIFY_EN (read back and compare each word).
module avr_flash_loader
  import avr_loader_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [15:0]       flash_wdata,
  output logic              flash_wren,
  input  logic [15:0]       flash_rdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra counter bit so a full-size image (LEN = 2**ADDR_W) does not wrap.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0]      len_q, len_d, new_len;
  logic [7:0]       sum_q, sum_d, sum_nxt;
  logic [7:0]       lo_q, lo_d;
  logic [15:0]      word_q, word_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             hold_q, hold_d;
  logic             err_q, err_d;
  logic             busy_st;
  logic             go_err;
  logic             header;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_rx),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_frame_err)
  );

`ifndef LOADER_VERIFY_EN
  // Readback data only matters when verification is built in.
  logic rdata_unused;
  assign rdata_unused = ^flash_rdata;
`endif

  assign cnt_inc = cnt_q + 1'b1;
  assign new_len = {len_q[15:8], rx_data};
  assign sum_nxt = sum_q + rx_data;

  // A frame is in progress from the accepted header until DONE or ERR.
  always_comb begin
    busy_st = 1'b0;
    case (state_q)
      S_LEN_H, S_LEN_L, S_DATA_L, S_DATA_H, S_WRITE,
`ifdef LOADER_VERIFY_EN
      S_VERIFY1, S_VERIFY2,
`endif
      S_CSUM:  busy_st = 1'b1;
      default: busy_st = 1'b0;
    endcase
  end

  // Loader state, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      lo_q    <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      lo_q    <= lo_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // Frame parser: next state, checksum, word counter and inter-byte timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_d   = sum_q;
    lo_d    = lo_q;
    word_d  = word_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    err_d   = err_q;
    go_err  = 1'b0;
    header  = 1'b0;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (rx_valid && rx_data == HEADER_BYTE) header = 1'b1;
      end
      S_LEN_H: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          state_d     = S_LEN_L;
        end
      end
      S_LEN_L: begin
        if (rx_valid) begin
          len_d = new_len;
          if (new_len == 16'd0)             state_d = S_CSUM;
          else if (32'(new_len) > MAX_LEN)  go_err  = 1'b1;
          else                              state_d = S_DATA_L;
        end
      end
      S_DATA_L: begin
        if (rx_valid) begin
          lo_d    = rx_data;
          state_d = S_DATA_H;
        end
      end
      S_DATA_H: begin
        if (rx_valid) begin
          word_d  = {rx_data, lo_q};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
`ifdef LOADER_VERIFY_EN
        // Address is held through the readback, so the counter advances later.
        state_d = S_VERIFY1;
`else
        cnt_d   = cnt_inc;
        state_d = (32'(cnt_inc) == 32'(len_q)) ? S_CSUM : S_DATA_L;
`endif
      end
`ifdef LOADER_VERIFY_EN
      S_VERIFY1: state_d = S_VERIFY2;
      S_VERIFY2: begin
        if (flash_rdata != word_q) begin
          go_err = 1'b1;
        end else begin
          cnt_d   = cnt_inc;
          state_d = (32'(cnt_inc) == 32'(len_q)) ? S_CSUM : S_DATA_L;
        end
      end
`endif
      S_CSUM: begin
        if (rx_valid) begin
          if (sum_nxt == 8'h00) begin
            state_d = S_DONE;
            hold_d  = 1'b0;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Every byte after the header feeds the checksum, CSUM included.
    if (busy_st && rx_valid) sum_d = sum_nxt;

    // Framing errors and stalls abort a frame; idle gaps between frames are free.
    if (busy_st) begin
      if (rx_frame_err)          go_err = 1'b1;
      else if (rx_valid)         tmo_d  = '0;
      else if (tmo_q == TMO_LAST) go_err = 1'b1;
      else                       tmo_d  = tmo_q + 1'b1;
    end else begin
      tmo_d = '0;
    end

    // Core stays held on error so a partial image never runs.
    if (go_err) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end

    if (header) begin
      state_d = S_LEN_H;
      hold_d  = 1'b1;
      err_d   = 1'b0;
      cnt_d   = '0;
      sum_d   = '0;
      len_d   = '0;
      tmo_d   = '0;
    end
  end

  assign flash_addr  = cnt_q[ADDR_W-1:0];
  assign flash_wdata = word_q;
  assign flash_wren  = (state_q == S_WRITE);
  assign done        = (state_q == S_DONE);
  assign busy        = busy_st;
  assign core_hold   = hold_q;
  assign error       = err_q;

endmodule
